// File: rtl/sap1_fp_loader_if.sv
// Byte-stream handshake into the sap1 front-panel loader.
// A byte moves on every sysclk edge where rx_valid and rx_ready are both high.
interface sap1_fp_loader_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  // Byte source, e.g. a UART receiver
  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  // Loader side
  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/sap1_fp_loader.sv
// Front-panel program loader for the sap1 core.
// Takes 2^ADR_W bytes from a valid/ready stream and writes them to consecutive addresses
// starting at 0 through the sap1 programming port. After the last byte it pulses fp_clear
// so the core restarts on the new program. A load is abandoned on an inter-byte timeout
// or an explicit abort, which leaves the sticky err flag set.
module sap1_fp_loader #(
  parameter int unsigned ADR_W      = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned WR_CYCLES  = 4,
  parameter int unsigned CLR_CYCLES = 8,
  parameter int unsigned TIMEOUT    = 1000000
) (
  input  logic              sysclk,
  input  logic              reset_n,
  sap1_fp_loader_if.slave   rx_if,
  input  logic              abort,
  output logic              fp_prog,
  output logic              fp_write,
  output logic [ADR_W-1:0]  fp_adr,
  output logic [DATA_W-1:0] fp_data,
  output logic              fp_clear,
  output logic              loading,
  output logic              done,
  output logic              err
);

  // One counter serves the strobe width, the clear width and the inter-byte timeout,
  // because only one of them is ever running.
  localparam int unsigned WrClrMax = (WR_CYCLES > CLR_CYCLES) ? WR_CYCLES : CLR_CYCLES;
  localparam int unsigned CntMax   = (WrClrMax > TIMEOUT) ? WrClrMax : TIMEOUT;
  localparam int unsigned CntW     = $clog2(CntMax + 1);

  localparam logic [CntW-1:0]  WrLast  = CntW'(WR_CYCLES - 1);
  localparam logic [CntW-1:0]  ClrLast = CntW'(CLR_CYCLES - 1);
  localparam logic [CntW-1:0]  ToLast  = CntW'(TIMEOUT - 1);
  localparam logic [ADR_W-1:0] AdrLast = {ADR_W{1'b1}};

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StWait,
    StClear
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              prog_q, prog_d;
  logic              write_q, write_d;
  logic              clear_q, clear_d;
  logic              ready_q, ready_d;
  logic              loading_q, loading_d;
  logic              xfer;
  logic              abortable;

  // rx_ready is registered, so a transfer is judged against the value the source sees
  assign xfer      = rx_if.rx_valid & ready_q;
  assign abortable = (state_q == StSetup) || (state_q == StStrobe) || (state_q == StWait);

  // Next-state logic: sequencing, address/data latching, counter and status flags
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    data_d  = data_q;
    err_d   = err_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          data_d  = rx_if.rx_data;
          adr_d   = '0;
          err_d   = 1'b0;
          state_d = StSetup;
        end
      end

      // Address and data settle one cycle ahead of the write strobe
      StSetup: begin
        cnt_d   = '0;
        state_d = StStrobe;
      end

      StStrobe: begin
        if (cnt_q == WrLast) begin
          cnt_d = '0;
          if (adr_q == AdrLast) begin
            state_d = StClear;
          end else begin
            // Address advances on the same edge the strobe drops, never while it is high
            adr_d   = adr_q + ADR_W'(1);
            state_d = StWait;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      // A byte arriving on the timeout cycle still wins
      StWait: begin
        if (xfer) begin
          data_d  = rx_if.rx_data;
          state_d = StSetup;
        end else if (cnt_q == ToLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StClear: begin
        if (cnt_q == ClrLast) begin
          cnt_d   = '0;
          adr_d   = '0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort cuts a load short, but a clear that has started always runs to completion
    if (abort && abortable) begin
      state_d = StIdle;
      err_d   = 1'b1;
    end
  end

  // Output decode from the next state, so every port comes straight from a flop
  always_comb begin
    prog_d    = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StWait);
    write_d   = (state_d == StStrobe);
    clear_d   = (state_d == StClear);
    ready_d   = (state_d == StIdle) || (state_d == StWait);
    loading_d = (state_d != StIdle);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      adr_q     <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      prog_q    <= 1'b0;
      write_q   <= 1'b0;
      clear_q   <= 1'b0;
      ready_q   <= 1'b1;
      loading_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      adr_q     <= adr_d;
      data_q    <= data_d;
      err_q     <= err_d;
      done_q    <= done_d;
      prog_q    <= prog_d;
      write_q   <= write_d;
      clear_q   <= clear_d;
      ready_q   <= ready_d;
      loading_q <= loading_d;
    end
  end

  assign rx_if.rx_ready = ready_q;
  assign fp_prog        = prog_q;
  assign fp_write       = write_q;
  assign fp_adr         = adr_q;
  assign fp_data        = data_q;
  assign fp_clear       = clear_q;
  assign loading        = loading_q;
  assign done           = done_q;
  assign err            = err_q;

  // Write and clear strobes are mutually exclusive
  a_write_clear_excl : assert property (
    @(posedge sysclk) disable iff (!reset_n) !(fp_write && fp_clear));

  // The sap1 sees steady address and data for the whole write strobe
  a_write_stable : assert property (
    @(posedge sysclk) disable iff (!reset_n)
    (fp_write && $past(fp_write)) |-> ($stable(fp_adr) && $stable(fp_data)));

  // Program mode is released while the core is being cleared
  a_clear_no_prog : assert property (
    @(posedge sysclk) disable iff (!reset_n) fp_clear |-> !fp_prog);

endmodule

// File: tb/tb_sap1_fp_loader.sv
// Directed bench for sap1_fp_loader with TIMEOUT shortened to 20 cycles.
// A negedge monitor logs every fp_write burst (address, data, length, stability) and
// counts fp_clear / done cycles; the test tasks compare those logs against hand values.
module tb_sap1_fp_loader;

  localparam int unsigned AdrW      = 4;
  localparam int unsigned DataW     = 8;
  localparam int unsigned WrCycles  = 4;
  localparam int unsigned ClrCycles = 8;
  localparam int unsigned Timeout   = 20;
  localparam int          MaxB      = 128;

  logic             sysclk  = 1'b0;
  logic             reset_n = 1'b1;
  logic             abort   = 1'b0;
  logic             fp_prog, fp_write, fp_clear, loading, done, err;
  logic [AdrW-1:0]  fp_adr;
  logic [DataW-1:0] fp_data;

  int tests  = 0;
  int failed = 0;

  sap1_fp_loader_if #(.DATA_W(DataW)) rx_if ();

  sap1_fp_loader #(
    .ADR_W     (AdrW),
    .DATA_W    (DataW),
    .WR_CYCLES (WrCycles),
    .CLR_CYCLES(ClrCycles),
    .TIMEOUT   (Timeout)
  ) dut (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .rx_if   (rx_if),
    .abort   (abort),
    .fp_prog (fp_prog),
    .fp_write(fp_write),
    .fp_adr  (fp_adr),
    .fp_data (fp_data),
    .fp_clear(fp_clear),
    .loading (loading),
    .done    (done),
    .err     (err)
  );

  always #5 sysclk = ~sysclk;

  // Burst log and strobe counters
  int               wr_n = 0;
  int               cur  = -1;
  logic [AdrW-1:0]  wr_adr [MaxB];
  logic [DataW-1:0] wr_dat [MaxB];
  int               wr_len [MaxB];
  bit               wr_bad [MaxB];
  int               clr_cycles     = 0;
  int               done_cycles    = 0;
  int               overlap_cycles = 0;
  logic             prev_write     = 1'b0;

  always @(negedge sysclk) begin
    if (fp_write === 1'b1 && fp_clear === 1'b1) overlap_cycles <= overlap_cycles + 1;
    if (fp_clear === 1'b1) clr_cycles <= clr_cycles + 1;
    if (done === 1'b1) done_cycles <= done_cycles + 1;
    if (fp_write === 1'b1 && prev_write !== 1'b1) begin
      if (wr_n < MaxB) begin
        wr_adr[wr_n] <= fp_adr;
        wr_dat[wr_n] <= fp_data;
        wr_len[wr_n] <= 1;
        wr_bad[wr_n] <= 1'b0;
        cur          <= wr_n;
      end
      wr_n <= wr_n + 1;
    end else if (fp_write === 1'b1 && cur >= 0) begin
      if (fp_adr !== wr_adr[cur] || fp_data !== wr_dat[cur]) wr_bad[cur] <= 1'b1;
      wr_len[cur] <= wr_len[cur] + 1;
    end
    prev_write <= fp_write;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  // Present a byte and wait (bounded) until it is taken; returns just after the transfer edge
  task automatic send_byte(input logic [7:0] b, input bit hold);
    int n = 0;
    rx_if.rx_data  = b;
    rx_if.rx_valid = 1'b1;
    while (rx_if.rx_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (rx_if.rx_ready !== 1'b1) begin
      tests++;
      failed++;
      $display("FAIL send_byte: rx_ready=%b after %0d cycles, want 1", rx_if.rx_ready, n);
    end
    tick();
    if (!hold) rx_if.rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (loading !== 1'b0 && n < limit) begin
      tick();
      n++;
    end
    tests++;
    if (loading !== 1'b0) begin
      failed++;
      $display("FAIL wait_idle: loading=%b after %0d cycles, want 0", loading, n);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = '0;
    #1 reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tests++;
    if ({fp_prog, fp_write, fp_clear} !== 3'b000) begin
      failed++;
      $display("FAIL reset_strobes: got %b want 000", {fp_prog, fp_write, fp_clear});
    end
    tests++;
    if ({fp_adr, fp_data} !== 12'h000) begin
      failed++;
      $display("FAIL reset_adr_data: got %h want 000", {fp_adr, fp_data});
    end
    tests++;
    if ({done, err, rx_if.rx_ready, loading} !== 4'b0010) begin
      failed++;
      $display("FAIL reset_status: got %b want 0010", {done, err, rx_if.rx_ready, loading});
    end
    tick();
    tests++;
    if ({rx_if.rx_ready, loading, fp_prog} !== 3'b100) begin
      failed++;
      $display("FAIL reset_idle: got %b want 100", {rx_if.rx_ready, loading, fp_prog});
    end
  endtask

  task automatic test_per_byte_timing();
    rx_if.rx_data  = 8'hA5;
    rx_if.rx_valid = 1'b1;
    tick();
    rx_if.rx_valid = 1'b0;
    tests++;
    if ({rx_if.rx_ready, fp_prog, fp_write} !== 3'b010) begin
      failed++;
      $display("FAIL timing_setup: got %b want 010", {rx_if.rx_ready, fp_prog, fp_write});
    end
    for (int c = 2; c <= 5; c++) begin
      tick();
      tests++;
      if ({fp_write, fp_adr, fp_data} !== {1'b1, 4'h0, 8'hA5}) begin
        failed++;
        $display("FAIL timing_strobe_c%0d: got %b/%h/%h want 1/0/a5", c, fp_write, fp_adr,
                 fp_data);
      end
    end
    tick();
    tests++;
    if ({fp_write, rx_if.rx_ready, fp_prog, fp_adr} !== {1'b0, 1'b1, 1'b1, 4'h1}) begin
      failed++;
      $display("FAIL timing_wait: got %b/%b/%b/%h want 0/1/1/1", fp_write, rx_if.rx_ready,
               fp_prog, fp_adr);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++;
    if ({loading, err, fp_prog, rx_if.rx_ready} !== 4'b0101) begin
      failed++;
      $display("FAIL abort_in_wait: got %b want 0101", {loading, err, fp_prog, rx_if.rx_ready});
    end
  endtask

  task automatic test_timeout();
    int c0 = clr_cycles;
    int d0 = done_cycles;
    int b0;
    int n  = 0;
    send_byte(8'h21, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h23, 1'b0);
    while (rx_if.rx_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    repeat (Timeout - 1) tick();
    tests++;
    if ({loading, err} !== 2'b10) begin
      failed++;
      $display("FAIL timeout_last_wait: got %b want 10", {loading, err});
    end
    tick();
    tests++;
    if ({err, fp_prog, loading, fp_clear} !== 4'b1000) begin
      failed++;
      $display("FAIL timeout_idle: got %b want 1000", {err, fp_prog, loading, fp_clear});
    end
    tick();
    tests++;
    if (clr_cycles != c0 || done_cycles != d0) begin
      failed++;
      $display("FAIL timeout_no_clear: clr %0d done %0d, want %0d %0d", clr_cycles, done_cycles,
               c0, d0);
    end
    b0 = wr_n;
    send_byte(8'h5A, 1'b0);
    tests++;
    if (err !== 1'b0) begin
      failed++;
      $display("FAIL timeout_err_clear: got %b want 0", err);
    end
    repeat (5) tick();
    tests++;
    if (wr_n != b0 + 1 || wr_adr[b0] !== 4'h0 || wr_dat[b0] !== 8'h5A || wr_len[b0] != 4) begin
      failed++;
      $display("FAIL timeout_reload: n=%0d adr=%h dat=%h len=%0d want %0d 0 5a 4", wr_n - b0,
               wr_adr[b0], wr_dat[b0], wr_len[b0], 1);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_full_load();
    int b0 = wr_n;
    int c0 = clr_cycles;
    int d0 = done_cycles;
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b1);
    rx_if.rx_valid = 1'b0;
    wait_idle(300);
    tests++;
    if (wr_n - b0 != 16) begin
      failed++;
      $display("FAIL full_burst_count: got %0d want 16", wr_n - b0);
    end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (wr_adr[b0+i] !== 4'(i) || wr_dat[b0+i] !== 8'(8'h10 + i) || wr_len[b0+i] != 4 ||
          wr_bad[b0+i]) begin
        failed++;
        $display("FAIL full_burst_%0d: adr=%h dat=%h len=%0d bad=%b want %h %h 4 0", i,
                 wr_adr[b0+i], wr_dat[b0+i], wr_len[b0+i], wr_bad[b0+i], 4'(i), 8'(8'h10 + i));
      end
    end
    tests++;
    if (clr_cycles - c0 != 8 || done_cycles - d0 != 1) begin
      failed++;
      $display("FAIL full_clear_done: clr=%0d done=%0d want 8 1", clr_cycles - c0,
               done_cycles - d0);
    end
    tests++;
    if ({err, fp_adr} !== 5'b0_0000) begin
      failed++;
      $display("FAIL full_end_state: err=%b adr=%h want 0 0", err, fp_adr);
    end
  endtask

  task automatic test_abort();
    int c0;
    int d0;
    int n = 0;
    for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i), 1'b0);
    send_byte(8'h45, 1'b0);
    tick();
    tests++;
    if ({fp_write, fp_adr} !== 5'b1_0101) begin
      failed++;
      $display("FAIL abort_pre: write=%b adr=%h want 1 5", fp_write, fp_adr);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++;
    if ({fp_write, fp_prog, err, loading} !== 4'b0010) begin
      failed++;
      $display("FAIL abort_strobe: got %b want 0010", {fp_write, fp_prog, err, loading});
    end
    c0 = clr_cycles;
    d0 = done_cycles;
    for (int i = 0; i < 16; i++) send_byte(8'(8'h60 + i), 1'b1);
    rx_if.rx_valid = 1'b0;
    while (fp_clear !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    abort = 1'b1;
    repeat (3) tick();
    abort = 1'b0;
    tests++;
    if (fp_clear !== 1'b1) begin
      failed++;
      $display("FAIL abort_clear_held: fp_clear=%b want 1", fp_clear);
    end
    wait_idle(50);
    tests++;
    if (clr_cycles - c0 != 8 || done_cycles - d0 != 1 || err !== 1'b0) begin
      failed++;
      $display("FAIL abort_in_clear: clr=%0d done=%0d err=%b want 8 1 0", clr_cycles - c0,
               done_cycles - d0, err);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    tests++;
    if ({err, loading} !== 2'b00) begin
      failed++;
      $display("FAIL abort_in_idle: got %b want 00", {err, loading});
    end
  endtask

  task automatic test_gappy();
    logic [7:0] gdat [16] = '{8'h3C, 8'h00, 8'hFF, 8'h81, 8'h5A, 8'hC3, 8'h7E, 8'h01,
                              8'h80, 8'h99, 8'h66, 8'hE7, 8'h18, 8'hAA, 8'h55, 8'hF0};
    int         gap  [16] = '{0, 3, 10, 1, 7, 0, 5, 2, 9, 4, 6, 8, 1, 10, 0, 3};
    int         b0 = wr_n;
    int         d0 = done_cycles;
    for (int i = 0; i < 16; i++) begin
      send_byte(gdat[i], 1'b0);
      // Junk on the bus while the loader is busy must never be taken
      for (int k = 0; k < 5; k++) begin
        rx_if.rx_data  = 8'hEE;
        rx_if.rx_valid = (rx_if.rx_ready === 1'b0) && ((k % 2) == 0);
        tick();
      end
      rx_if.rx_valid = 1'b0;
      repeat (gap[i]) tick();
    end
    wait_idle(100);
    tests++;
    if (wr_n - b0 != 16) begin
      failed++;
      $display("FAIL gappy_burst_count: got %0d want 16", wr_n - b0);
    end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (wr_adr[b0+i] !== 4'(i) || wr_dat[b0+i] !== gdat[i] || wr_len[b0+i] != 4 ||
          wr_bad[b0+i]) begin
        failed++;
        $display("FAIL gappy_burst_%0d: adr=%h dat=%h len=%0d bad=%b want %h %h 4 0", i,
                 wr_adr[b0+i], wr_dat[b0+i], wr_len[b0+i], wr_bad[b0+i], 4'(i), gdat[i]);
      end
    end
    tests++;
    if (done_cycles - d0 != 1 || err !== 1'b0) begin
      failed++;
      $display("FAIL gappy_done: done=%0d err=%b want 1 0", done_cycles - d0, err);
    end
  endtask

  task automatic test_async_reset();
    int d0 = done_cycles;
    send_byte(8'h77, 1'b0);
    tick();
    tests++;
    if (fp_write !== 1'b1) begin
      failed++;
      $display("FAIL areset_pre: fp_write=%b want 1", fp_write);
    end
    #3 reset_n = 1'b0;
    #1;
    tests++;
    if ({fp_write, fp_prog, loading, fp_clear, err} !== 5'b00000) begin
      failed++;
      $display("FAIL areset_strobes: got %b want 00000", {fp_write, fp_prog, loading, fp_clear,
                                                         err});
    end
    tests++;
    if ({fp_adr, fp_data, rx_if.rx_ready} !== 13'h0001) begin
      failed++;
      $display("FAIL areset_adr: adr=%h data=%h ready=%b want 0 00 1", fp_adr, fp_data,
               rx_if.rx_ready);
    end
    @(posedge sysclk);
    #2 reset_n = 1'b1;
    repeat (3) tick();
    tests++;
    if (done_cycles != d0 || loading !== 1'b0) begin
      failed++;
      $display("FAIL areset_no_done: done=%0d loading=%b want %0d 0", done_cycles, loading, d0);
    end
  endtask

  initial begin
    test_reset();
    test_per_byte_timing();
    test_timeout();
    test_full_load();
    test_abort();
    test_gappy();
    test_async_reset();
    tests++;
    if (overlap_cycles != 0) begin
      failed++;
      $display("FAIL write_clear_overlap: got %0d cycles want 0", overlap_cycles);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
